// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and the MIPS datapath.
// The controller side (master) drives the mux selects and write enables and
// reads the decoded instruction fields, the ALU zero flag and memory ready.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] aluControl;
  logic [1:0] PCSrc;
  logic       PCEn;

  modport master (
    input  op, funct, zero, mem_ready,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, aluControl, PCSrc, PCEn
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, aluControl, PCSrc, PCEn
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM. Sequences fetch/decode/execute over one shared
// memory port and one ALU, waits on mem_ready for every memory access, flags
// undecodable instructions and counts retired instructions.
module multicycle_controller #(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus,
  output logic                    illegal_op,
  output logic                    retired,
  output logic [CNT_W-1:0]        instr_count,
  output logic [3:0]              state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] count_reg;
  // op/funct are only valid in DECODE, so what later states need is captured there
  logic             is_sw_reg;
  logic [2:0]       alu_ex_reg;

  logic             funct_legal;
  logic [2:0]       funct_alu;

  logic pc_en_raw;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;
  logic illegal_raw;
  logic retired_raw;

  // R-type funct decode: legality and the ALU operation it selects
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = ALU_ADD;
    case (bus.funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_legal = 1'b0;
    endcase
  end

  // Next-state logic and per-state datapath controls (enables are ungated here)
  always_comb begin
    state_next     = state_reg;
    bus.IorD       = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.aluControl = ALU_ADD;
    bus.PCSrc      = 2'b00;
    pc_en_raw      = 1'b0;
    ir_write_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    reg_write_raw  = 1'b0;
    illegal_raw    = 1'b0;
    retired_raw    = 1'b0;

    case (state_reg)
      S_FETCH: begin
        bus.ALUSrcB  = 2'b01;
        ir_write_raw = bus.mem_ready;
        pc_en_raw    = bus.mem_ready;
        if (bus.mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = funct_legal ? S_EXECUTE : S_ILLEGAL;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_next  = is_sw_reg ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.IorD = 1'b1;
        if (bus.mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.MemtoReg  = 1'b1;
        reg_write_raw = 1'b1;
        retired_raw   = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.IorD      = 1'b1;
        mem_write_raw = 1'b1;
        retired_raw   = bus.mem_ready;
        if (bus.mem_ready) state_next = S_FETCH;
      end
      S_EXECUTE: begin
        bus.ALUSrcA    = 1'b1;
        bus.aluControl = alu_ex_reg;
        state_next     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegDst    = 1'b1;
        reg_write_raw = 1'b1;
        retired_raw   = 1'b1;
        state_next    = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = 1'b1;
        bus.aluControl = ALU_SUB;
        bus.PCSrc      = 2'b01;
        pc_en_raw      = bus.zero;
        retired_raw    = 1'b1;
        state_next     = S_FETCH;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        retired_raw   = 1'b1;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        bus.PCSrc   = 2'b10;
        pc_en_raw   = 1'b1;
        retired_raw = 1'b1;
        state_next  = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_raw = 1'b1;
        state_next  = S_FETCH;
      end
      default: begin
        // unused encodings: recover quietly with everything deasserted
        bus.aluControl = 3'b000;
        state_next     = S_FETCH;
      end
    endcase
  end

  // Reset suppresses every side-effecting enable immediately, not just at the edge
  always_comb begin
    bus.PCEn     = pc_en_raw & ~reset;
    bus.IRWrite  = ir_write_raw & ~reset;
    bus.MemWrite = mem_write_raw & ~reset;
    bus.RegWrite = reg_write_raw & ~reset;
    illegal_op   = illegal_raw & ~reset;
    retired      = retired_raw & ~reset;
  end

  // State register, retired counter and decode-time captures
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_FETCH;
      count_reg  <= '0;
      is_sw_reg  <= 1'b0;
      alu_ex_reg <= ALU_ADD;
    end else begin
      state_reg <= state_next;
      if (retired_raw) count_reg <= count_reg + 1'b1;
      if (state_reg == S_DECODE) begin
        is_sw_reg  <= (bus.op == OP_SW);
        alu_ex_reg <= funct_alu;
      end
    end
  end

  assign instr_count = count_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: every driven cycle pushes the
// expected state/controls/count, and a negedge monitor pops and compares.
module tb_multicycle_controller;
  localparam int CNT_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic             clk = 1'b0;
  logic             reset;
  logic             illegal_op;
  logic             retired;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  multicycle_controller_if bus ();

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .illegal_op  (illegal_op),
    .retired     (retired),
    .instr_count (instr_count),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       st;
    logic [16:0]      ctrl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   exp_count = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expected controls for a state, straight from the state table
  // Packing: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB aluControl PCSrc PCEn illegal retired
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic z,
                                           input logic [2:0] alu, input logic rst);
    logic iord, mw, irw, rd, m2r, rw, srca, pcen, ill, ret;
    logic [1:0] srcb, pcsrc;
    logic [2:0] ac;
    {iord, mw, irw, rd, m2r, rw, srca, pcen, ill, ret} = '0;
    srcb = 2'b00; pcsrc = 2'b00; ac = 3'b010;
    case (st)
      4'd0:  begin srcb = 2'b01; irw = mr; pcen = mr; end
      4'd1:  srcb = 2'b11;
      4'd2:  begin srca = 1'b1; srcb = 2'b10; end
      4'd3:  iord = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; ret = 1'b1; end
      4'd5:  begin iord = 1'b1; mw = 1'b1; ret = mr; end
      4'd6:  begin srca = 1'b1; ac = alu; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; ret = 1'b1; end
      4'd8:  begin srca = 1'b1; ac = 3'b110; pcsrc = 2'b01; pcen = z; ret = 1'b1; end
      4'd9:  begin srca = 1'b1; srcb = 2'b10; end
      4'd10: begin rw = 1'b1; ret = 1'b1; end
      4'd11: begin pcsrc = 2'b10; pcen = 1'b1; ret = 1'b1; end
      4'd12: ill = 1'b1;
      default: ac = 3'b000;
    endcase
    if (rst) {pcen, irw, mw, rw, ill, ret} = '0;
    return {iord, mw, irw, rd, m2r, rw, srca, srcb, ac, pcsrc, pcen, ill, ret};
  endfunction

  // Drive one cycle and push its expectation; the model counter follows retired
  task automatic do_cycle(input logic [3:0] st, input logic mr, input logic z,
                          input logic [2:0] alu, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.mem_ready = mr;
    bus.zero      = z;
    e.st   = st;
    e.ctrl = exp_ctrl(st, mr, z, alu, rst);
    e.cnt  = exp_count[CNT_W-1:0];
    sb_q.push_back(e);
    if (rst) exp_count = 0;
    else if (e.ctrl[0]) exp_count = (exp_count + 1) % (1 << CNT_W);
  endtask

  // One full instruction; fw = extra FETCH wait cycles, mw = extra memory wait cycles
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw,
                           input int mw, input logic z);
    logic [2:0] alu;
    logic       legal;
    bus.op    = o;
    bus.funct = f;
    legal = 1'b1;
    alu   = 3'b010;
    case (f)
      6'b100000: alu = 3'b010;
      6'b100010: alu = 3'b110;
      6'b100100: alu = 3'b000;
      6'b100101: alu = 3'b001;
      6'b101010: alu = 3'b111;
      default:   legal = 1'b0;
    endcase
    repeat (fw) do_cycle(4'd0, 1'b0, rb(), alu, 1'b0);
    do_cycle(4'd0, 1'b1, rb(), alu, 1'b0);
    do_cycle(4'd1, rb(), rb(), alu, 1'b0);
    case (o)
      OP_LW: begin
        do_cycle(4'd2, rb(), rb(), alu, 1'b0);
        repeat (mw) do_cycle(4'd3, 1'b0, rb(), alu, 1'b0);
        do_cycle(4'd3, 1'b1, rb(), alu, 1'b0);
        do_cycle(4'd4, rb(), rb(), alu, 1'b0);
      end
      OP_SW: begin
        do_cycle(4'd2, rb(), rb(), alu, 1'b0);
        repeat (mw) do_cycle(4'd5, 1'b0, rb(), alu, 1'b0);
        do_cycle(4'd5, 1'b1, rb(), alu, 1'b0);
      end
      OP_RTYPE: begin
        if (legal) begin
          do_cycle(4'd6, rb(), rb(), alu, 1'b0);
          do_cycle(4'd7, rb(), rb(), alu, 1'b0);
        end else begin
          do_cycle(4'd12, rb(), rb(), alu, 1'b0);
        end
      end
      OP_BEQ:  do_cycle(4'd8, rb(), z, alu, 1'b0);
      OP_ADDI: begin
        do_cycle(4'd9, rb(), rb(), alu, 1'b0);
        do_cycle(4'd10, rb(), rb(), alu, 1'b0);
      end
      OP_J:    do_cycle(4'd11, rb(), rb(), alu, 1'b0);
      default: do_cycle(4'd12, rb(), rb(), alu, 1'b0);
    endcase
    $display("txn op=%b funct=%b fetch_wait=%0d mem_wait=%0d zero=%b model_count=%0d",
             o, f, fw, mw, z, exp_count);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest pushed expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("state", {28'd0, state}, {28'd0, e.st});
      check_val("ctrl", {15'd0, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                         bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.aluControl, bus.PCSrc,
                         bus.PCEn, illegal_op, retired}, {15'd0, e.ctrl});
      check_val("instr_count", 32'(instr_count), 32'(e.cnt));
    end
  end

  initial begin
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    bus.op        = 6'd0;
    bus.funct     = 6'd0;
    repeat (2) @(posedge clk);
    // reset state: FETCH, count 0, enables held low even with mem_ready high
    do_cycle(4'd0, 1'b1, 1'b0, 3'b010, 1'b1);
    $display("txn reset");

    run_instr(OP_ADDI, 6'b000000, 0, 0, 1'b0);
    run_instr(OP_LW, 6'b000000, 1, 2, 1'b0);
    run_instr(OP_BEQ, 6'b000000, 0, 0, 1'b1);
    run_instr(OP_BEQ, 6'b000000, 0, 0, 1'b0);
    run_instr(OP_RTYPE, 6'b100000, 0, 0, 1'b0);
    run_instr(OP_RTYPE, 6'b100010, 0, 0, 1'b0);
    run_instr(OP_RTYPE, 6'b100100, 2, 0, 1'b0);
    run_instr(OP_RTYPE, 6'b100101, 0, 0, 1'b0);
    run_instr(OP_RTYPE, 6'b101010, 0, 0, 1'b0);
    run_instr(OP_RTYPE, 6'b000111, 0, 0, 1'b0);
    run_instr(6'b111111, 6'b100000, 0, 0, 1'b0);
    run_instr(OP_SW, 6'b000000, 0, 0, 1'b0);
    run_instr(OP_SW, 6'b000000, 0, 2, 1'b0);
    run_instr(OP_LW, 6'b000000, 0, 0, 1'b0);

    for (int i = 0; i < 16; i++) run_instr(OP_J, 6'b000000, 0, 0, 1'b0);

    // SW stalled three cycles, then aborted by reset
    bus.op    = OP_SW;
    bus.funct = 6'b000000;
    do_cycle(4'd0, 1'b1, rb(), 3'b010, 1'b0);
    do_cycle(4'd1, rb(), rb(), 3'b010, 1'b0);
    do_cycle(4'd2, rb(), rb(), 3'b010, 1'b0);
    repeat (3) do_cycle(4'd5, 1'b0, rb(), 3'b010, 1'b0);
    do_cycle(4'd5, 1'b0, rb(), 3'b010, 1'b1);
    do_cycle(4'd0, rb(), rb(), 3'b010, 1'b1);
    $display("txn sw_abort_by_reset model_count=%0d", exp_count);

    run_instr(OP_ADDI, 6'b000000, 0, 0, 1'b0);
    run_instr(OP_RTYPE, 6'b101010, 1, 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
